// File: rtl/tron_pkg.sv
// Shared definitions for the tron collision arbiter: screen and arena geometry,
// player colours, FSM state encoding and bitmap addressing helpers.
// Optional build macro: ARENA_WALL_EN (arena walls count as kills).
package tron_pkg;

  localparam int X_MAX  = 160;
  localparam int Y_MAX  = 120;
  localparam int X_LO   = 10;
  localparam int X_HI   = 150;
  localparam int Y_LO   = 17;
  localparam int Y_HI   = 109;
  localparam int ADDR_W = 15;
  localparam int DEPTH  = X_MAX * Y_MAX;

  localparam logic [2:0]        COLOUR_P1 = 3'b001;
  localparam logic [2:0]        COLOUR_P2 = 3'b100;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_IDLE  = 3'd1,
    ST_RD1   = 3'd2,
    ST_RD2   = 3'd3,
    ST_CHK   = 3'd4,
    ST_WR1   = 3'd5,
    ST_WR2   = 3'd6,
    ST_OVER  = 3'd7
  } state_t;

  // Row-major bitmap address; y*X_MAX + x fits in 15 bits for every 8/7-bit input.
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [7:0] px, input logic [6:0] py);
    return ADDR_W'(py) * ADDR_W'(X_MAX) + ADDR_W'(px);
  endfunction

  // Position-only kill: off-screen always, arena walls only when enabled.
  function automatic logic out_of_bounds(input logic [7:0] px, input logic [6:0] py);
    logic oob;
    oob = (px >= 8'(X_MAX)) | (py >= 7'(Y_MAX));
`ifdef ARENA_WALL_EN
    oob = oob | (px < 8'(X_LO)) | (px > 8'(X_HI)) | (py < 7'(Y_LO)) | (py > 7'(Y_HI));
`else
    oob = oob | 1'b0;
`endif
    return oob;
  endfunction

endpackage

// File: rtl/tron_occupancy_ram.sv
// 19200x1 single-port occupancy bitmap with 1-cycle synchronous read.
// Contents are not reset; the arbiter clears them after every reset.
module tron_occupancy_ram
  import tron_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic              din,
  output logic              dout
);

  logic mem_r [0:DEPTH-1];

  // Write port plus registered read; addresses past the bitmap read as empty.
  always_ff @(posedge clk) begin
    if (addr <= LAST_ADDR) begin
      if (we) begin
        mem_r[addr] <= din;
      end
      dout <= mem_r[addr];
    end else begin
      dout <= 1'b0;
    end
  end

endmodule

// File: rtl/tron_collision_arbiter.sv
// Arbitrates both tron heads onto one VGA plot port: once per tick it reads the
// occupancy bitmap for both heads, decides deaths, and plots the survivors.
// Optional build macro: ARENA_WALL_EN (arena walls count as kills).
module tron_collision_arbiter
  import tron_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       tick,
  input  logic [7:0] p1_x,
  input  logic [6:0] p1_y,
  input  logic [7:0] p2_x,
  input  logic [6:0] p2_y,
  output logic       ready,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       dead1,
  output logic       dead2,
  output logic       game_over,
  output logic       overrun
);

  state_t              state_r;
  logic [ADDR_W-1:0]   clr_cnt_r;
  logic [7:0]          p1x_r, p2x_r;
  logic [6:0]          p1y_r, p2y_r;
  logic                occ1_r;

  logic [ADDR_W-1:0]   addr1_s, addr2_s, ram_addr_s;
  logic                ram_we_s, ram_din_s, ram_dout_s;
  logic                head_on_s, kill1_s, kill2_s;

  assign addr1_s = pix_addr(p1x_r, p1y_r);
  assign addr2_s = pix_addr(p2x_r, p2y_r);

  // Bitmap port steering: clear sweep, the two head reads, then survivor writes.
  always_comb begin
    ram_addr_s = addr1_s;
    ram_we_s   = 1'b0;
    ram_din_s  = 1'b0;
    case (state_r)
      ST_CLEAR: begin
        ram_addr_s = clr_cnt_r;
        ram_we_s   = 1'b1;
        ram_din_s  = 1'b0;
      end
      ST_RD1: ram_addr_s = addr1_s;
      ST_RD2: ram_addr_s = addr2_s;
      ST_WR1: begin
        ram_addr_s = addr1_s;
        ram_we_s   = ~dead1;
        ram_din_s  = 1'b1;
      end
      ST_WR2: begin
        ram_addr_s = addr2_s;
        ram_we_s   = ~dead2;
        ram_din_s  = 1'b1;
      end
      default: ram_addr_s = addr1_s;
    endcase
  end

  // Kill decision; p2's bit arrives straight from the RAM during CHK.
  always_comb begin
    head_on_s = (p1x_r == p2x_r) && (p1y_r == p2y_r);
    kill1_s   = occ1_r     | head_on_s | out_of_bounds(p1x_r, p1y_r);
    kill2_s   = ram_dout_s | head_on_s | out_of_bounds(p2x_r, p2y_r);
  end

  tron_occupancy_ram u_ram (
    .clk  (clk),
    .we   (ram_we_s),
    .addr (ram_addr_s),
    .din  (ram_din_s),
    .dout (ram_dout_s)
  );

  // Main FSM with registered VGA, status and death outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r   <= ST_CLEAR;
      clr_cnt_r <= '0;
      p1x_r     <= 8'd0;
      p1y_r     <= 7'd0;
      p2x_r     <= 8'd0;
      p2y_r     <= 7'd0;
      occ1_r    <= 1'b0;
      ready     <= 1'b0;
      x         <= 8'd0;
      y         <= 7'd0;
      colour    <= 3'd0;
      plot      <= 1'b0;
      dead1     <= 1'b0;
      dead2     <= 1'b0;
      game_over <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (tick && (state_r != ST_IDLE)) begin
        overrun <= 1'b1;
      end
      case (state_r)
        ST_CLEAR: begin
          plot <= 1'b0;
          if (clr_cnt_r == LAST_ADDR) begin
            clr_cnt_r <= '0;
            ready     <= 1'b1;
            state_r   <= ST_IDLE;
          end else begin
            clr_cnt_r <= clr_cnt_r + ADDR_W'(1);
          end
        end
        ST_IDLE: begin
          plot <= 1'b0;
          if (tick) begin
            p1x_r   <= p1_x;
            p1y_r   <= p1_y;
            p2x_r   <= p2_x;
            p2y_r   <= p2_y;
            ready   <= 1'b0;
            state_r <= ST_RD1;
          end
        end
        ST_RD1: state_r <= ST_RD2;
        ST_RD2: begin
          occ1_r  <= ram_dout_s;
          state_r <= ST_CHK;
        end
        ST_CHK: begin
          dead1     <= kill1_s;
          dead2     <= kill2_s;
          game_over <= kill1_s | kill2_s;
          if (!kill1_s) begin
            plot   <= 1'b1;
            x      <= p1x_r;
            y      <= p1y_r;
            colour <= COLOUR_P1;
          end else begin
            plot <= 1'b0;
          end
          state_r <= ST_WR1;
        end
        ST_WR1: begin
          if (!dead2) begin
            plot   <= 1'b1;
            x      <= p2x_r;
            y      <= p2y_r;
            colour <= COLOUR_P2;
          end else begin
            plot <= 1'b0;
          end
          state_r <= ST_WR2;
        end
        ST_WR2: begin
          plot <= 1'b0;
          if (dead1 || dead2) begin
            state_r <= ST_OVER;
          end else begin
            ready   <= 1'b1;
            state_r <= ST_IDLE;
          end
        end
        ST_OVER: plot <= 1'b0;
        default: begin
          plot    <= 1'b0;
          ready   <= 1'b0;
          state_r <= ST_CLEAR;
        end
      endcase
    end
  end

endmodule
